// File: rtl/puzzle_pkg.sv
// Shared types and board-layout helpers for the sliding-tile puzzle engine.
package puzzle_pkg;

  typedef enum logic [1:0] {SOLVED = 2'd0, SCAN = 2'd1, PLAY = 2'd2, ERR = 2'd3} state_e;
  typedef enum logic [1:0] {DIR_L = 2'd0, DIR_R = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_e;

  // Widest board the layout helper can build; callers slice to their own width.
  localparam int MAX_BW = 1024;

  function automatic int cell_lsb(int r, int c, int cols, int n, int tw);
    return (n - 1 - (r * cols + c)) * tw;
  endfunction

  function automatic logic [MAX_BW-1:0] solved_board(int rows, int cols, int tw);
    logic [MAX_BW-1:0] b;
    int n;
    b = '0;
    n = rows * cols;
    for (int i = 0; i < n - 1; i++)
      b = b | (MAX_BW'(i + 1) << cell_lsb(0, i, n, n, tw));
    return b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for the four move buttons.
module btn_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [3:0] rise
);

  logic [3:0] btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/slide_puzzle_engine.sv
// Sliding-tile puzzle core: board load + blank scan, edge-triggered moves, solved detection.
//   state  | meaning
//   SOLVED | board in solved layout, buttons ignored
//   SCAN   | walking cells of a freshly loaded board to find the blank
//   PLAY   | accepting one move per button press
//   ERR    | loaded board did not contain exactly one blank
module slide_puzzle_engine
  import puzzle_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int TW   = 4,
  parameter int MCW  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [ROWS*COLS*TW-1:0]   load_board,
  input  logic                      btn_l,
  input  logic                      btn_r,
  input  logic                      btn_u,
  input  logic                      btn_d,
  output logic [ROWS*COLS*TW-1:0]   board,
  output logic [$clog2(ROWS)-1:0]   blank_row,
  output logic [$clog2(COLS)-1:0]   blank_col,
  output logic [MCW-1:0]            move_cnt,
  output logic                      move_ok,
  output logic                      move_rej,
  output logic                      ready,
  output logic                      solved,
  output logic                      error
);

  localparam int N  = ROWS * COLS;
  localparam int BW = N * TW;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(BW);

  localparam logic [1:0] ST_SOLVED = SOLVED;
  localparam logic [1:0] ST_SCAN   = SCAN;
  localparam logic [1:0] ST_PLAY   = PLAY;
  localparam logic [1:0] ST_ERR    = ERR;

  localparam logic [MAX_BW-1:0] SOLVED_FULL  = solved_board(ROWS, COLS, TW);
  localparam logic [BW-1:0]     SOLVED_BOARD = SOLVED_FULL[BW-1:0];

  logic [1:0]    state;
  logic [3:0]    rise;
  logic [RW-1:0] scan_row;
  logic [CW-1:0] scan_col;
  logic [1:0]    zero_cnt;
  logic [IW-1:0] scan_lsb;
  logic          scan_zero;
  logic          scan_last;
  logic          one_blank;

  logic          mv_legal;
  logic [RW-1:0] tgt_row;
  logic [CW-1:0] tgt_col;
  logic [IW-1:0] blank_lsb;
  logic [IW-1:0] tgt_lsb;
  logic [BW-1:0] moved_board;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   ({btn_d, btn_u, btn_r, btn_l}),
    .rise  (rise)
  );

  assign scan_lsb  = IW'(cell_lsb(int'(scan_row), int'(scan_col), COLS, N, TW));
  assign scan_zero = (board[scan_lsb +: TW] == '0);
  assign scan_last = (scan_row == RW'(ROWS - 1)) && (scan_col == CW'(COLS - 1));
  // zero_cnt saturates at 2, so "exactly one" is decided from the count so far plus this cell.
  assign one_blank = scan_zero ? (zero_cnt == 2'd0) : (zero_cnt == 2'd1);

  always_comb begin
    int br, bc, tr, tc;
    br = int'(blank_row);
    bc = int'(blank_col);
    tr = br;
    tc = bc;
    if ($onehot(rise)) begin
      if (rise[DIR_L] && bc > 0)             tc = bc - 1;
      else if (rise[DIR_R] && bc < COLS - 1) tc = bc + 1;
      else if (rise[DIR_U] && br > 0)        tr = br - 1;
      else if (rise[DIR_D] && br < ROWS - 1) tr = br + 1;
    end
    mv_legal  = (tr != br) || (tc != bc);
    tgt_row   = RW'(tr);
    tgt_col   = CW'(tc);
    blank_lsb = IW'(cell_lsb(br, bc, COLS, N, TW));
    tgt_lsb   = IW'(cell_lsb(tr, tc, COLS, N, TW));
    moved_board = board;
    moved_board[blank_lsb +: TW] = board[tgt_lsb +: TW];
    moved_board[tgt_lsb +: TW]   = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SOLVED;
      board     <= SOLVED_BOARD;
      blank_row <= RW'(ROWS - 1);
      blank_col <= CW'(COLS - 1);
      move_cnt  <= '0;
      move_ok   <= 1'b0;
      move_rej  <= 1'b0;
      scan_row  <= '0;
      scan_col  <= '0;
      zero_cnt  <= '0;
    end else begin
      move_ok  <= 1'b0;
      move_rej <= 1'b0;
      if (load) begin
        board    <= load_board;
        state    <= ST_SCAN;
        scan_row <= '0;
        scan_col <= '0;
        zero_cnt <= '0;
        move_cnt <= '0;
      end else begin
        case (state)
          ST_SCAN: begin
            if (scan_zero) begin
              blank_row <= scan_row;
              blank_col <= scan_col;
              if (zero_cnt != 2'd2) zero_cnt <= zero_cnt + 2'd1;
            end
            if (scan_last) begin
              if (!one_blank)                  state <= ST_ERR;
              else if (board == SOLVED_BOARD)  state <= ST_SOLVED;
              else                             state <= ST_PLAY;
            end else if (scan_col == CW'(COLS - 1)) begin
              scan_col <= '0;
              scan_row <= scan_row + 1'b1;
            end else begin
              scan_col <= scan_col + 1'b1;
            end
          end
          ST_PLAY: begin
            // The solved check looks at the board registered by the previous move.
            if (board == SOLVED_BOARD) begin
              state <= ST_SOLVED;
            end else if (|rise) begin
              if (mv_legal) begin
                board     <= moved_board;
                blank_row <= tgt_row;
                blank_col <= tgt_col;
                move_ok   <= 1'b1;
                if (move_cnt != '1) move_cnt <= move_cnt + 1'b1;
              end else begin
                move_rej <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready  = (state == ST_PLAY);
  assign solved = (state == ST_SOLVED);
  assign error  = (state == ST_ERR);

endmodule

// File: tb/tb_slide_puzzle_engine.sv
// Bench for slide_puzzle_engine: directed vector table, corner sequences, randomized run vs. array model.
module tb_slide_puzzle_engine;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int TW   = 4;
  localparam int N    = ROWS * COLS;
  localparam int BW   = N * TW;
  localparam logic [BW-1:0] SOLVED_B = 36'h123456780;

  localparam int M_SOL  = 0;
  localparam int M_SCAN = 1;
  localparam int M_PLAY = 2;
  localparam int M_ERR  = 3;

  localparam logic [3:0] B_L = 4'b0001;
  localparam logic [3:0] B_R = 4'b0010;
  localparam logic [3:0] B_U = 4'b0100;
  localparam logic [3:0] B_D = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [BW-1:0] load_board = '0;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;

  logic [BW-1:0] board;
  logic [1:0] blank_row, blank_col;
  logic [9:0] move_cnt;
  logic move_ok, move_rej, ready, solved, error;

  logic [BW-1:0] s_board;
  logic [1:0] s_blank_row, s_blank_col;
  logic [1:0] s_move_cnt;
  logic s_move_ok, s_move_rej, s_ready, s_solved, s_error;

  slide_puzzle_engine #(.ROWS(ROWS), .COLS(COLS), .TW(TW), .MCW(10)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_board(load_board),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .board(board), .blank_row(blank_row), .blank_col(blank_col), .move_cnt(move_cnt),
    .move_ok(move_ok), .move_rej(move_rej), .ready(ready), .solved(solved), .error(error)
  );

  slide_puzzle_engine #(.ROWS(ROWS), .COLS(COLS), .TW(TW), .MCW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load(load), .load_board(load_board),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .board(s_board), .blank_row(s_blank_row), .blank_col(s_blank_col), .move_cnt(s_move_cnt),
    .move_ok(s_move_ok), .move_rej(s_move_rej), .ready(s_ready), .solved(s_solved), .error(s_error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: tiles as a flat array, mode as a small integer.
  int m_t[N];
  int m_br, m_bc, m_cnt, m_mode, m_left;
  logic [3:0] m_prev;
  bit m_ok, m_rej;

  function automatic bit m_is_solved();
    for (int i = 0; i < N; i++)
      if (m_t[i] != ((i < N - 1) ? i + 1 : 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [BW-1:0] m_pack();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[(N - 1 - i) * TW +: TW] = TW'(m_t[i]);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_t[i] = (i < N - 1) ? i + 1 : 0;
    m_br = ROWS - 1; m_bc = COLS - 1; m_cnt = 0; m_mode = M_SOL; m_left = 0;
    m_prev = '0; m_ok = 1'b0; m_rej = 1'b0;
  endtask

  task automatic model_edge(bit ld, logic [BW-1:0] lb, logic [3:0] b);
    logic [3:0] r;
    int z, zi, dr, dc, nr, nc;
    r = b & ~m_prev;
    m_prev = b;
    m_ok = 1'b0;
    m_rej = 1'b0;
    if (ld) begin
      for (int i = 0; i < N; i++) m_t[i] = int'(lb[(N - 1 - i) * TW +: TW]);
      m_mode = M_SCAN; m_left = N; m_cnt = 0;
    end else if (m_mode == M_SCAN) begin
      m_left--;
      if (m_left == 0) begin
        z = 0; zi = 0;
        for (int i = 0; i < N; i++) if (m_t[i] == 0) begin z++; zi = i; end
        if (z != 1) m_mode = M_ERR;
        else begin
          m_br = zi / COLS; m_bc = zi % COLS;
          m_mode = m_is_solved() ? M_SOL : M_PLAY;
        end
      end
    end else if (m_mode == M_PLAY) begin
      if (m_is_solved()) m_mode = M_SOL;
      else if (r != 0) begin
        dr = 0; dc = 0;
        case (r)
          B_L: dc = -1;
          B_R: dc = 1;
          B_U: dr = -1;
          B_D: dr = 1;
          default: ;
        endcase
        nr = m_br + dr; nc = m_bc + dc;
        if ((dr != 0 || dc != 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
          m_t[m_br * COLS + m_bc] = m_t[nr * COLS + nc];
          m_t[nr * COLS + nc] = 0;
          m_br = nr; m_bc = nc;
          m_cnt++;
          m_ok = 1'b1;
        end else m_rej = 1'b1;
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".board"}, board, m_pack());
    check({tag, ".move_ok"}, move_ok, m_ok);
    check({tag, ".move_rej"}, move_rej, m_rej);
    check({tag, ".move_cnt"}, move_cnt, (m_cnt > 1023) ? 1023 : m_cnt);
    check({tag, ".sat_cnt"}, s_move_cnt, (m_cnt > 3) ? 3 : m_cnt);
    check({tag, ".ready"}, ready, m_mode == M_PLAY);
    check({tag, ".solved"}, solved, m_mode == M_SOL);
    check({tag, ".error"}, error, m_mode == M_ERR);
    if (m_mode == M_PLAY || m_mode == M_SOL) begin
      check({tag, ".blank_row"}, blank_row, m_br);
      check({tag, ".blank_col"}, blank_col, m_bc);
    end
  endtask

  task automatic cycle(bit ld, logic [BW-1:0] lb, logic [3:0] b);
    load = ld;
    load_board = lb;
    {btn_d, btn_u, btn_r, btn_l} = b;
    @(posedge clk);
    model_edge(ld, lb, b);
    #1;
    load = 1'b0;
  endtask

  typedef struct {
    bit ld;
    logic [BW-1:0] lb;
    logic [3:0] btn;
    int hold;
    logic [BW-1:0] e_board;
    bit e_ok;
    bit e_rej;
    int e_cnt;
    int e_st;
    int e_br;
    int e_bc;
  } vec_t;

  function automatic vec_t mk(bit ld, logic [BW-1:0] lb, logic [3:0] btn, int hold,
                              logic [BW-1:0] eb, bit ok, bit rej, int cnt, int st, int br, int bc);
    vec_t v;
    v.ld = ld; v.lb = lb; v.btn = btn; v.hold = hold; v.e_board = eb;
    v.e_ok = ok; v.e_rej = rej; v.e_cnt = cnt; v.e_st = st; v.e_br = br; v.e_bc = bc;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_board();
    int a[N];
    int j, t;
    logic [BW-1:0] b;
    case ($urandom_range(0, 9))
      0: return 36'h123456708;
      1: return 36'h123450786;
      default: ;
    endcase
    for (int i = 0; i < N; i++) a[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    if ($urandom_range(0, 5) == 0) a[$urandom_range(0, N - 1)] = 0;
    b = '0;
    for (int i = 0; i < N; i++) b[(N - 1 - i) * TW +: TW] = TW'(a[i]);
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    vec_t v;
    logic [3:0] rb;
    model_reset();

    #12;
    check("rst.board", board, SOLVED_B);
    check("rst.blank_row", blank_row, 2);
    check("rst.blank_col", blank_col, 2);
    check("rst.solved", solved, 1);
    check("rst.ready", ready, 0);
    check("rst.move_cnt", move_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    tv.push_back(mk(0, '0, B_L, 1, SOLVED_B, 0, 0, 0, M_SOL, 2, 2));
    tv.push_back(mk(0, '0, 4'b0, 1, SOLVED_B, 0, 0, 0, M_SOL, 2, 2));
    tv.push_back(mk(1, 36'h123456708, 4'b0, 1, 36'h123456708, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 8, 36'h123456708, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h123456708, 0, 0, 0, M_PLAY, 2, 1));
    tv.push_back(mk(0, '0, B_R, 1, SOLVED_B, 1, 0, 1, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, 4'b0, 1, SOLVED_B, 0, 0, 1, M_SOL, 2, 2));
    tv.push_back(mk(1, 36'h812345670, 4'b0, 1, 36'h812345670, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 9, 36'h812345670, 0, 0, 0, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, B_R, 1, 36'h812345670, 0, 1, 0, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h812345670, 0, 0, 0, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, B_D, 1, 36'h812345670, 0, 1, 0, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h812345670, 0, 0, 0, M_PLAY, 2, 2));
    tv.push_back(mk(0, '0, B_U, 1, 36'h812340675, 1, 0, 1, M_PLAY, 1, 2));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h812340675, 0, 0, 1, M_PLAY, 1, 2));
    tv.push_back(mk(0, '0, B_L, 1, 36'h812304675, 1, 0, 2, M_PLAY, 1, 1));
    tv.push_back(mk(0, '0, B_L, 5, 36'h812304675, 0, 0, 2, M_PLAY, 1, 1));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h812304675, 0, 0, 2, M_PLAY, 1, 1));
    tv.push_back(mk(0, '0, B_L | B_U, 1, 36'h812304675, 0, 1, 2, M_PLAY, 1, 1));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h812304675, 0, 0, 2, M_PLAY, 1, 1));
    tv.push_back(mk(1, 36'h123456708, B_R, 1, 36'h123456708, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 9, 36'h123456708, 0, 0, 0, M_PLAY, 2, 1));
    tv.push_back(mk(1, 36'h023456700, 4'b0, 1, 36'h023456700, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 9, 36'h023456700, 0, 0, 0, M_ERR, -1, -1));
    tv.push_back(mk(1, 36'h123456789, 4'b0, 1, 36'h123456789, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 9, 36'h123456789, 0, 0, 0, M_ERR, -1, -1));
    tv.push_back(mk(1, SOLVED_B, 4'b0, 1, SOLVED_B, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 9, SOLVED_B, 0, 0, 0, M_SOL, 2, 2));
    tv.push_back(mk(1, 36'h812345670, 4'b0, 1, 36'h812345670, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 4, 36'h812345670, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(1, 36'h123456708, 4'b0, 1, 36'h123456708, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 8, 36'h123456708, 0, 0, 0, M_SCAN, -1, -1));
    tv.push_back(mk(0, '0, 4'b0, 1, 36'h123456708, 0, 0, 0, M_PLAY, 2, 1));

    foreach (tv[k]) begin
      v = tv[k];
      for (int h = 0; h < v.hold; h++) cycle(v.ld && h == 0, v.lb, v.btn);
      check($sformatf("vec%0d.board", k), board, v.e_board);
      check($sformatf("vec%0d.move_ok", k), move_ok, v.e_ok);
      check($sformatf("vec%0d.move_rej", k), move_rej, v.e_rej);
      check($sformatf("vec%0d.move_cnt", k), move_cnt, v.e_cnt);
      check($sformatf("vec%0d.ready", k), ready, v.e_st == M_PLAY);
      check($sformatf("vec%0d.solved", k), solved, v.e_st == M_SOL);
      check($sformatf("vec%0d.error", k), error, v.e_st == M_ERR);
      if (v.e_br >= 0) begin
        check($sformatf("vec%0d.blank_row", k), blank_row, v.e_br);
        check($sformatf("vec%0d.blank_col", k), blank_col, v.e_bc);
      end
    end

    // Five legal moves: the 2-bit counter must stop at 3.
    cycle(1, 36'h812345670, 4'b0);
    check_all("sat.load");
    for (int i = 0; i < 9; i++) cycle(0, '0, 4'b0);
    check_all("sat.scan");
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, (i % 2 == 0) ? B_U : B_D);
      check_all($sformatf("sat.move%0d", i));
      cycle(0, '0, 4'b0);
    end
    check("sat.cnt_full", move_cnt, 5);
    check("sat.cnt_sat", s_move_cnt, 3);
    check("sat.board", board, 36'h812340675);

    // Asynchronous reset in the middle of a scan.
    cycle(1, 36'h123456708, 4'b0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 4'b0);
    check("midscan.ready", ready, 0);
    rst_n = 1'b0;
    #1;
    check("areset.board", board, SOLVED_B);
    check("areset.solved", solved, 1);
    check("areset.ready", ready, 0);
    check("areset.blank_row", blank_row, 2);
    check("areset.blank_col", blank_col, 2);
    check("areset.sat_cnt", s_move_cnt, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(0, '0, 4'b0);
    check_all("post_reset");

    // Randomized run against the reference model.
    rb = '0;
    cycle(1, rand_board(), 4'b0);
    check_all("rnd.first");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 9))
          0: rb = B_L;
          1: rb = B_R;
          2: rb = B_U;
          3: rb = B_D;
          4: rb = 4'($urandom);
          default: rb = 4'b0;
        endcase
      end
      if ($urandom_range(0, 24) == 0) cycle(1, rand_board(), rb);
      else cycle(0, '0, rb);
      check_all($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
